// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back arbiter and pending-write scoreboard for the 8 x 16-bit register
// file of the multicycle RISC core. The ALU result path and the load-return
// path share the register file's single write port. A round-robin arbiter
// picks one of them, and the winning write is registered onto the
// WE/Waddr/Wdata inputs. The scoreboard keeps one busy bit per register so
// that the control FSM can stall issue on RAW/WAW hazards.
//
// Ports
//   clk                    system clock (register file samples on ~clk)
//   rst                    synchronous, active-high reset
//   alu_valid/ready        ALU write-back handshake (ready is combinational)
//   alu_addr/data          ALU destination register and result
//   mem_valid/ready        load-return handshake (ready is combinational)
//   mem_addr/data          load destination register and data
//   rsv_en/rsv_addr        reserve a destination register at issue
//   rsv_err                one-cycle pulse: reservation refused (already busy)
//   qa_addr/qa_busy        hazard query A (combinational)
//   qb_addr/qb_busy        hazard query B (combinational)
//   busy                   scoreboard vector, one bit per register
//   rf_we/waddr/wdata      registered register-file write port
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [2:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic        rsv_en,
  input  logic [2:0]  rsv_addr,
  output logic        rsv_err,
  input  logic [2:0]  qa_addr,
  input  logic [2:0]  qb_addr,
  output logic        qa_busy,
  output logic        qb_busy,
  output logic [7:0]  busy,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e      r_last_grant;
  logic [7:0]  r_busy;
  logic        r_rsv_err;
  logic        r_rf_we;
  logic [2:0]  r_rf_waddr;
  logic [15:0] r_rf_wdata;

  logic        w_alu_win;
  logic        w_mem_win;
  logic        w_xfer;
  logic [2:0]  w_win_addr;
  logic [15:0] w_win_data;

  logic [7:0]  w_set_mask;
  logic [7:0]  w_clr_mask;
  logic [7:0]  w_busy_next;
  logic        w_rsv_refuse;

  // Arbitration. A lone requester always wins. On contention the requester
  // that did not win last time gets the port. Reset masks both readies so
  // that nothing transfers while the block is being reset.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_alu_win = 1'b0;
    w_mem_win = 1'b0;
    if (!rst) begin
      if (alu_valid && (!mem_valid || r_last_grant == GRANT_MEM)) begin
        w_alu_win = 1'b1;
      end else if (mem_valid) begin
        w_mem_win = 1'b1;
      end
    end
  end

  assign w_xfer     = w_alu_win | w_mem_win;
  assign w_win_addr = w_alu_win ? alu_addr : mem_addr;
  assign w_win_data = w_alu_win ? alu_data : mem_data;

  // Scoreboard next state. The commit now on rf_* retires its register at
  // this edge. A reservation of that same register at the same edge is a
  // legal back-to-back reuse. The set wins, and it is not refused even
  // though the bit still reads 1 during this cycle.
  always_comb begin
    w_set_mask   = 8'h00;
    w_clr_mask   = 8'h00;
    w_rsv_refuse = 1'b0;
    if (r_rf_we) begin
      w_clr_mask[r_rf_waddr] = 1'b1;
    end
    if (rsv_en) begin
      if (!r_busy[rsv_addr] || w_clr_mask[rsv_addr]) begin
        w_set_mask[rsv_addr] = 1'b1;
      end else begin
        w_rsv_refuse = 1'b1;
      end
    end
  end

  assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_MEM;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 3'd0;
      r_rf_wdata   <= 16'h0000;
    end else begin
      r_rf_we <= w_xfer;
      if (w_xfer) begin
        r_last_grant <= w_alu_win ? GRANT_ALU : GRANT_MEM;
        r_rf_waddr   <= w_win_addr;
        r_rf_wdata   <= w_win_data;
      end
    end
  end

  // The busy vector is reset explicitly. A commit dropped by reset would
  // otherwise leave its register marked busy forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 8'h00;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_next;
      r_rsv_err <= w_rsv_refuse;
    end
  end

  assign alu_ready = w_alu_win;
  assign mem_ready = w_mem_win;
  assign qa_busy   = r_busy[qa_addr];
  assign qb_busy   = r_busy[qb_addr];
  assign busy      = r_busy;
  assign rsv_err   = r_rsv_err;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;

endmodule
